lfsr_gen: RTL and testbench

- Parametrised LFSR pseudo-random generator. Successor to the team's fixed 3-bit LFSR, generalised in width, polynomial and structure (Fibonacci or Galois).
- Adds step enable, runtime seed load with zero-lock protection, serial output, and period measurement with a wrap pulse.
- Used as the PRBS and test-pattern source for datapath benches and on-chip stimulus.

---
 rtl/lfsr_gen.sv | 103 ++++++++++
 tb/tb_lfsr_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with step enable, seed load
// with zero-lock protection, serial output and period measurement.
module lfsr_gen #(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] POLY   = 8'h1D,
    parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned      GALOIS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    if (WIDTH < 2) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be 2 or more");
    end
    if (POLY[0] == 1'b0) begin : g_bad_poly
        $error("lfsr_gen: POLY[0] must be 1");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] period_r;
    logic             wrap_r;
    logic             lock_r;

    logic [WIDTH-1:0] q_step;
    logic             fb;
    logic [WIDTH-1:0] seed_fix;
    logic             seed_zero;

    // Next LFSR state for one step, Fibonacci or Galois form.
    always_comb begin
        fb     = 1'b0;
        q_step = '0;
        if (GALOIS != 0) begin
            q_step = {q_r[WIDTH-2:0], 1'b0} ^ (q_r[WIDTH-1] ? POLY : '0);
        end else begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                fb = fb ^ (POLY[k] & q_r[WIDTH-1-k]);
            end
            q_step = {q_r[WIDTH-2:0], fb};
        end
    end

    // Zero seeds would lock the register; substitute SEED instead.
    always_comb begin
        seed_zero = (seed_in == '0);
        seed_fix  = seed_zero ? SEED : seed_in;
    end

    // State, cycle start, step counter and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r      <= SEED;
            start_r  <= SEED;
            cnt_r    <= '0;
            period_r <= '0;
            wrap_r   <= 1'b0;
            lock_r   <= 1'b0;
        end else if (load) begin
            q_r     <= seed_fix;
            start_r <= seed_fix;
            cnt_r   <= '0;
            lock_r  <= seed_zero;
            wrap_r  <= 1'b0;
        end else if (en) begin
            q_r    <= q_step;
            lock_r <= 1'b0;
            if (q_step == start_r) begin
                wrap_r   <= 1'b1;
                period_r <= cnt_r + ONE;
                cnt_r    <= '0;
            end else begin
                wrap_r <= 1'b0;
                cnt_r  <= cnt_r + ONE;
            end
        end else begin
            wrap_r <= 1'b0;
            lock_r <= 1'b0;
        end
    end

    assign q       = q_r;
    assign bit_out = q_r[WIDTH-1];
    assign wrap    = wrap_r;
    assign period  = period_r;
    assign lockup  = lock_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for lfsr_gen across four configurations
// (4-bit Fibonacci, 4-bit Galois, 4-bit x^4+1, default 8-bit).
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] en_v   = '0;
    logic [3:0] load_v = '0;
    logic [7:0] seed_a [4];

    logic [3:0] q0, q1, q2, p0, p1, p2;
    logic [7:0] q3, p3;
    logic [3:0] bo, wr, lk;

    logic [7:0] oq [4];
    logic [7:0] op [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(4), .POLY(4'b0011), .SEED(4'b0001), .GALOIS(0)) u_fib (
        .clk(clk), .rst(rst), .en(en_v[0]), .load(load_v[0]), .seed_in(seed_a[0][3:0]),
        .q(q0), .bit_out(bo[0]), .wrap(wr[0]), .period(p0), .lockup(lk[0]));

    lfsr_gen #(.WIDTH(4), .POLY(4'b0011), .SEED(4'b0001), .GALOIS(1)) u_gal (
        .clk(clk), .rst(rst), .en(en_v[1]), .load(load_v[1]), .seed_in(seed_a[1][3:0]),
        .q(q1), .bit_out(bo[1]), .wrap(wr[1]), .period(p1), .lockup(lk[1]));

    lfsr_gen #(.WIDTH(4), .POLY(4'b0001), .SEED(4'b0001), .GALOIS(0)) u_rot (
        .clk(clk), .rst(rst), .en(en_v[2]), .load(load_v[2]), .seed_in(seed_a[2][3:0]),
        .q(q2), .bit_out(bo[2]), .wrap(wr[2]), .period(p2), .lockup(lk[2]));

    lfsr_gen u_def (
        .clk(clk), .rst(rst), .en(en_v[3]), .load(load_v[3]), .seed_in(seed_a[3]),
        .q(q3), .bit_out(bo[3]), .wrap(wr[3]), .period(p3), .lockup(lk[3]));

    assign oq[0] = {4'h0, q0};
    assign oq[1] = {4'h0, q1};
    assign oq[2] = {4'h0, q2};
    assign oq[3] = q3;
    assign op[0] = {4'h0, p0};
    assign op[1] = {4'h0, p1};
    assign op[2] = {4'h0, p2};
    assign op[3] = p3;

    // Reference model, one slot per instance.
    int unsigned mw   [4] = '{4, 4, 4, 8};
    logic [7:0]  mpoly[4] = '{8'h03, 8'h03, 8'h01, 8'h1D};
    logic [7:0]  mseed[4] = '{8'h01, 8'h01, 8'h01, 8'h01};
    int          mgal [4] = '{0, 1, 0, 0};
    logic [7:0]  mq[4], mst[4], mcnt[4], mper[4];
    logic        mwrap[4], mlock[4];

    typedef struct {
        int         idx;
        logic [7:0] q;
        logic       bo;
        logic       wrap;
        logic [7:0] per;
        logic       lock;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input int i, input logic [7:0] s);
        logic [7:0] mask;
        logic [7:0] r;
        logic       f;
        mask = 8'((16'd1 << mw[i]) - 16'd1);
        if (mgal[i] != 0) begin
            r = (s << 1) & mask;
            if (s[mw[i]-1]) r = r ^ mpoly[i];
        end else begin
            f = 1'b0;
            for (int k = 0; k < int'(mw[i]); k++)
                if (mpoly[i][k]) f = f ^ s[int'(mw[i])-1-k];
            r = ((s << 1) | {7'd0, f}) & mask;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i] = mseed[i]; mst[i] = mseed[i]; mcnt[i] = '0;
            mper[i] = '0; mwrap[i] = 1'b0; mlock[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        logic [7:0] s, n, mask;
        exp_t e;
        mask = 8'((16'd1 << mw[i]) - 16'd1);
        if (load_v[i]) begin
            s = seed_a[i] & mask;
            mlock[i] = (s == 8'd0);
            if (s == 8'd0) s = mseed[i];
            mq[i] = s; mst[i] = s; mcnt[i] = '0; mwrap[i] = 1'b0;
        end else if (en_v[i]) begin
            n = model_next(i, mq[i]);
            mlock[i] = 1'b0;
            if (n == mst[i]) begin
                mwrap[i] = 1'b1; mper[i] = mcnt[i] + 8'd1; mcnt[i] = '0;
            end else begin
                mwrap[i] = 1'b0; mcnt[i] = mcnt[i] + 8'd1;
            end
            mq[i] = n;
        end else begin
            mwrap[i] = 1'b0; mlock[i] = 1'b0;
        end
        e.idx = i; e.q = mq[i]; e.bo = mq[i][mw[i]-1];
        e.wrap = mwrap[i]; e.per = mper[i]; e.lock = mlock[i];
        sb.push_back(e);
    endtask

    // One clock: predict, let the edge happen, compare all instances.
    task automatic cycle();
        exp_t e;
        for (int i = 0; i < 4; i++) model_edge(i);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val($sformatf("sb_q%0d", e.idx),      32'(oq[e.idx]),  32'(e.q));
            check_val($sformatf("sb_bit%0d", e.idx),    32'(bo[e.idx]),  32'(e.bo));
            check_val($sformatf("sb_wrap%0d", e.idx),   32'(wr[e.idx]),  32'(e.wrap));
            check_val($sformatf("sb_period%0d", e.idx), 32'(op[e.idx]),  32'(e.per));
            check_val($sformatf("sb_lock%0d", e.idx),   32'(lk[e.idx]),  32'(e.lock));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] fib_tbl [6];
        logic [3:0] gal_tbl [6];
        logic [3:0] pat;
        fib_tbl = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6};
        gal_tbl = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6};
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) seed_a[i] = '0;

        // Reset state
        #12;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rst_q%0d", i),      32'(oq[i]), 32'h1);
            check_val($sformatf("rst_period%0d", i), 32'(op[i]), 32'h0);
            check_val($sformatf("rst_wrap%0d", i),   32'(wr[i]), 32'h0);
            check_val($sformatf("rst_lock%0d", i),   32'(lk[i]), 32'h0);
        end
        model_reset();
        rst = 1'b1;

        // Free-running stepping of the three 4-bit instances
        en_v = 4'b0111;
        for (int n = 1; n <= 20; n++) begin
            cycle();
            if (n <= 5) begin
                check_val("fib_seq", 32'(q0), 32'(fib_tbl[n]));
                check_val("gal_seq", 32'(q1), 32'(gal_tbl[n]));
            end
            if (n == 4 || n == 8) check_val("rot_wrap", 32'(wr[2]), 32'h1);
            if (n == 15) begin
                check_val("fib_wrap15", 32'(wr[0]), 32'h1);
                check_val("fib_q15",    32'(q0),    32'h1);
                check_val("gal_wrap15", 32'(wr[1]), 32'h1);
            end
        end
        check_val("fib_period", 32'(p0), 32'd15);
        check_val("gal_period", 32'(p1), 32'd15);
        check_val("rot_period", 32'(p2), 32'd4);

        // Zero-seed load and load-over-enable on the 8-bit instance
        en_v = '0;
        load_v[3] = 1'b1; seed_a[3] = 8'h00;
        cycle();
        check_val("zero_load_q",    32'(q3),    32'h01);
        check_val("zero_load_lock", 32'(lk[3]), 32'h1);
        check_val("zero_load_wrap", 32'(wr[3]), 32'h0);
        load_v[3] = 1'b0;
        cycle();
        check_val("lock_pulse_end", 32'(lk[3]), 32'h0);
        load_v[3] = 1'b1; en_v[3] = 1'b1; seed_a[3] = 8'hA5;
        cycle();
        check_val("load_pri_q",    32'(q3),    32'hA5);
        check_val("load_pri_lock", 32'(lk[3]), 32'h0);
        load_v[3] = 1'b0; en_v[3] = 1'b0;

        // Gapped enable, then reload mid-cycle on the Fibonacci instance
        for (int n = 0; n < 12; n++) begin
            en_v[0] = pat[n % 4];
            cycle();
        end
        load_v[0] = 1'b1; en_v[0] = 1'b1; seed_a[0] = 8'h06;
        cycle();
        check_val("reload_q", 32'(q0), 32'h6);
        load_v[0] = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            cycle();
            if (n == 14) check_val("reload_nowrap14", 32'(wr[0]), 32'h0);
        end
        check_val("reload_wrap",   32'(wr[0]), 32'h1);
        check_val("reload_q15",    32'(q0),    32'h6);
        check_val("reload_period", 32'(p0),    32'd15);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_q",      32'(q0),    32'h1);
        check_val("arst_period", 32'(p0),    32'h0);
        check_val("arst_wrap",   32'(wr[0]), 32'h0);
        check_val("arst_q_def",  32'(q3),    32'h01);
        model_reset();
        #2;
        rst = 1'b1;
        en_v = 4'b1111;
        cycle();
        check_val("post_rst_q", 32'(q0), 32'h2);
        for (int n = 0; n < 6; n++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
